mem_port_arbiter: RTL and testbench

//  Shares the single-ported unified memory between two requesters: port 0 is the

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter_rr_arb2.sv | 18 +
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// port index constants and the round-robin pick rule.
// Latency: n/a (types/functions only). Backpressure: n/a.
// Contents: arb_state_e, P_CPU/P_DMA, rr_pick().
package mem_port_arbiter_pkg;

   // IDLE -> BUSY -> RESP -> IDLE; the fourth code is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   // Port index constants; a grant index is one of these.
   localparam logic P_CPU = 1'b0;
   localparam logic P_DMA = 1'b1;

   // Winner index for a two-way round-robin. When both request, the port that
   // was not served last wins; otherwise the single requester wins. The result
   // only matters when at least one request is present.
   function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
      logic idx;
      if (req0 && req1) begin
         idx = ~last;
      end else begin
         idx = req1;
      end
      return idx;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the requester-side and memory-side signals of the arbiter.
// Latency: n/a (wires only). Backpressure: req held until ack (req/ack handshake).
// Ports (per signal, "slave" = arbiter view):
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requests into the arbiter
//   ack0/ack1, err0/err1, rdata                      : completion back to requesters
//   mem_en, mem_we, mem_addr, mem_wdata              : access strobe/data to memory
//   mem_rdata, mem_ready                             : memory response
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // requester side
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          ack0;
   logic          ack1;
   logic          err0;
   logic          err1;
   logic [DW-1:0] rdata;

   // memory side
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   // master: the requesters plus the memory model (everything around the arbiter)
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  ack0, ack1, err0, err1, rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );

   // slave: the arbiter itself
   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output ack0, ack1, err0, err1, rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker used by the arbiter in IDLE.
// Latency: zero (pure combinational). Backpressure: none, caller decides when to use the grant.
// Ports: i_req0/i_req1 requests, i_last index served last,
//        o_gnt_vld any request present, o_gnt_idx winning port index.
module mem_port_arbiter_rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last,
   output logic o_gnt_vld,
   output logic o_gnt_idx
);

   assign o_gnt_vld = i_req0 | i_req1;
   assign o_gnt_idx = rr_pick(i_req0, i_req1, i_last);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the CPU port (0) and the DMA/loader port (1).
// Latency: grant at the IDLE edge, ack two cycles after the request with a zero-wait memory;
//   each memory wait state adds a cycle, one IDLE bubble between transactions.
// Backpressure: requesters hold req until their ack pulse; memory stalls via mem_ready,
//   bounded by a timeout after 2**TMO_W-1 BUSY cycles (ack with err).
// Ports: i_clk, i_rst (async, active-high), io_bus (slave modport, see interface),
//        o_busy (high in any state other than IDLE).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int TMO_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   mem_port_arbiter_if.slave     io_bus,
   output logic                  o_busy
);

   arb_state_e       r_state;
   logic             r_last;       // port index that completed last
   logic             r_gnt;        // port index of the transaction in flight
   logic [TMO_W-1:0] r_cnt;        // BUSY cycles elapsed for this transaction
   logic             r_mem_en;
   logic             r_mem_we;
   logic [AW-1:0]    r_mem_addr;
   logic [DW-1:0]    r_mem_wdata;
   logic [DW-1:0]    r_rdata;
   logic             r_ack0;
   logic             r_ack1;
   logic             r_err0;
   logic             r_err1;

   logic             w_gnt_vld;
   logic             w_gnt_idx;
   logic             w_sel_we;
   logic [AW-1:0]    w_sel_addr;
   logic [DW-1:0]    w_sel_wdata;
   logic [TMO_W-1:0] w_cnt_nxt;
   logic             w_tmo;

   mem_port_arbiter_rr_arb2 u_rr (
      .i_req0    (io_bus.req0),
      .i_req1    (io_bus.req1),
      .i_last    (r_last),
      .o_gnt_vld (w_gnt_vld),
      .o_gnt_idx (w_gnt_idx)
   );

   // Request fields of the winning port, captured at the grant edge only.
   assign w_sel_we    = (w_gnt_idx == P_DMA) ? io_bus.we1    : io_bus.we0;
   assign w_sel_addr  = (w_gnt_idx == P_DMA) ? io_bus.addr1  : io_bus.addr0;
   assign w_sel_wdata = (w_gnt_idx == P_DMA) ? io_bus.wdata1 : io_bus.wdata0;

   // The timeout fires in the BUSY cycle that would bring the counter to
   // all-ones, so exactly 2**TMO_W-1 BUSY cycles are spent before giving up.
   assign w_cnt_nxt = r_cnt + 1'b1;
   assign w_tmo     = &w_cnt_nxt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_last      <= P_DMA;     // so that port 0 wins the first tie
         r_gnt       <= P_CPU;
         r_cnt       <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
         r_ack0      <= 1'b0;
         r_ack1      <= 1'b0;
         r_err0      <= 1'b0;
         r_err1      <= 1'b0;
      end else begin
         // ack/err are single-cycle pulses, only raised on the BUSY->RESP edge
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_err0 <= 1'b0;
         r_err1 <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_gnt_vld) begin
                  r_gnt       <= w_gnt_idx;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= w_sel_we;
                  r_mem_addr  <= w_sel_addr;
                  r_mem_wdata <= w_sel_wdata;
                  r_cnt       <= '0;
                  r_state     <= ST_BUSY;
               end
            end

            ST_BUSY: begin
               // mem_ready takes priority over a simultaneous timeout
               if (io_bus.mem_ready) begin
                  if (!r_mem_we) begin
                     r_rdata <= io_bus.mem_rdata;
                  end
                  r_mem_en <= 1'b0;
                  r_mem_we <= 1'b0;
                  r_ack0   <= (r_gnt == P_CPU);
                  r_ack1   <= (r_gnt == P_DMA);
                  r_state  <= ST_RESP;
               end else if (w_tmo) begin
                  r_mem_en <= 1'b0;
                  r_mem_we <= 1'b0;
                  r_ack0   <= (r_gnt == P_CPU);
                  r_ack1   <= (r_gnt == P_DMA);
                  r_err0   <= (r_gnt == P_CPU);
                  r_err1   <= (r_gnt == P_DMA);
                  r_state  <= ST_RESP;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end

            ST_RESP: begin
               // ack is visible this cycle; fairness pointer moves to the served port
               r_last  <= r_gnt;
               r_cnt   <= '0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign io_bus.ack0      = r_ack0;
   assign io_bus.ack1      = r_ack1;
   assign io_bus.err0      = r_err0;
   assign io_bus.err1      = r_err1;
   assign io_bus.rdata     = r_rdata;
   assign io_bus.mem_en    = r_mem_en;
   assign io_bus.mem_we    = r_mem_we;
   assign io_bus.mem_addr  = r_mem_addr;
   assign io_bus.mem_wdata = r_mem_wdata;
   assign o_busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a wait-state memory model and a
// scoreboard of expected completions (port, err, rdata) checked on every ack.
module tb_mem_port_arbiter;

   logic clk;
   logic rst;
   logic busy;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter #(.AW(32), .DW(32), .TMO_W(3)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus),
      .o_busy (busy)
   );

   typedef struct {
      logic        port;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   int          wait_n = 0;      // memory wait states before mem_ready
   int          bcnt   = 0;
   logic [31:0] last_rd = 32'h0; // expected rdata after the most recent read

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mdl(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5_5A5A);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input string tag, input int limit);
      int n;
      n = 0;
      step();
      while (!(bus.ack0 || bus.ack1) && n < limit) begin
         step();
         n++;
      end
      chk(tag, {63'd0, bus.ack0 | bus.ack1}, 64'd1);
   endtask

   task automatic push(input logic port, input logic err, input logic we, input logic [31:0] a);
      exp_t e;
      if (!we && !err) last_rd = mdl(a);
      e.port  = port;
      e.err   = err;
      e.rdata = last_rd;
      sb.push_back(e);
   endtask

   // Memory model: answers after wait_n BUSY cycles, never outside mem_en.
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      forever begin
         step();
         if (bus.mem_en) begin
            if (bcnt == wait_n) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = mdl(bus.mem_addr);
            end else begin
               bus.mem_ready = 1'b0;
            end
            bcnt++;
         end else begin
            bus.mem_ready = 1'b0;
            bcnt = 0;
         end
      end
   end

   // Scoreboard: every ack must match the next expected completion.
   initial begin
      exp_t e;
      forever begin
         step();
         if (bus.ack0 || bus.ack1) begin
            chk("ack_onehot", {63'd0, bus.ack0 & bus.ack1}, 64'd0);
            if (sb.size() == 0) begin
               chk("ack_unexpected", 64'(sb.size()), 64'd1);
            end else begin
               e = sb.pop_front();
               chk("sb_port", {63'd0, bus.ack1}, {63'd0, e.port});
               chk("sb_err", {63'd0, (e.port ? bus.err1 : bus.err0)}, {63'd0, e.err});
               chk("sb_rdata", {32'd0, bus.rdata}, {32'd0, e.rdata});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      rst = 1'b1;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.we0 = 1'b0;  bus.we1 = 1'b0;
      bus.addr0 = '0;  bus.addr1 = '0;
      bus.wdata0 = '0; bus.wdata1 = '0;
      step(); step();

      // ---- reset state
      chk("rst_mem_en", {63'd0, bus.mem_en}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_ack", {62'd0, bus.ack0, bus.ack1}, 64'd0);
      chk("rst_rdata", {32'd0, bus.rdata}, 64'd0);
      chk("rst_mem_addr", {32'd0, bus.mem_addr}, 64'd0);
      rst = 1'b0;

      // ---- zero-wait read on port 0
      wait_n = 0;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h100;
      push(1'b0, 1'b0, 1'b0, 32'h100);
      step();
      chk("zw_busy", {63'd0, busy}, 64'd1);
      chk("zw_mem_en", {63'd0, bus.mem_en}, 64'd1);
      chk("zw_mem_addr", {32'd0, bus.mem_addr}, 64'h100);
      chk("zw_ack_early", {63'd0, bus.ack0}, 64'd0);
      step();
      chk("zw_ack0_c2", {63'd0, bus.ack0}, 64'd1);
      chk("zw_ack1", {63'd0, bus.ack1}, 64'd0);
      chk("zw_rdata", {32'd0, bus.rdata}, 64'hDEADBEEF);
      bus.req0 = 1'b0;
      step();
      chk("zw_ack_pulse", {63'd0, bus.ack0}, 64'd0);
      chk("zw_idle", {63'd0, busy}, 64'd0);

      // ---- reset mid-BUSY (port 1 write), then tie must go to port 0
      wait_n = 5;
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h80; bus.wdata1 = 32'h55;
      step(); step();
      chk("rb_busy_pre", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      #1;
      chk("rb_mem_en", {63'd0, bus.mem_en}, 64'd0);
      chk("rb_busy", {63'd0, busy}, 64'd0);
      chk("rb_ack", {62'd0, bus.ack0, bus.ack1}, 64'd0);
      chk("rb_rdata", {32'd0, bus.rdata}, 64'd0);
      bus.req1 = 1'b0; bus.we1 = 1'b0;
      last_rd = 32'h0;
      step();
      rst = 1'b0;

      // ---- contention: both held for six transactions
      wait_n = 1;
      bus.req0 = 1'b1; bus.addr0 = 32'h200;
      bus.req1 = 1'b1; bus.addr1 = 32'h300;
      for (int k = 0; k < 6; k++) push(k[0], 1'b0, 1'b0, k[0] ? 32'h300 : 32'h200);
      step();
      chk("ct_first_grant", {32'd0, bus.mem_addr}, 64'h200);
      for (int k = 0; k < 6; k++) begin
         if (k == 0) begin
            cnt = 0;
            while (!(bus.ack0 || bus.ack1) && cnt < 10) begin step(); cnt++; end
            chk("ct_ack_0", {63'd0, bus.ack0 | bus.ack1}, 64'd1);
         end else begin
            wait_ack("ct_ack", 10);
         end
         chk("ct_order", {63'd0, bus.ack1}, {63'd0, k[0]});
         if (k == 5) begin
            bus.req0 = 1'b0; bus.req1 = 1'b0;
         end
         step();
         chk("ct_bubble", {63'd0, busy}, 64'd0);
      end

      // ---- timeout: memory never answers
      wait_n = 1000;
      bus.req0 = 1'b1; bus.addr0 = 32'h500;
      push(1'b0, 1'b1, 1'b0, 32'h500);
      cnt = 0;
      step();
      while (!bus.ack0 && cnt < 30) begin
         if (bus.mem_en) cnt++;
         step();
      end
      chk("to_busy_cycles", 64'(cnt), 64'd7);
      chk("to_ack0", {63'd0, bus.ack0}, 64'd1);
      chk("to_err0", {63'd0, bus.err0}, 64'd1);
      chk("to_mem_en", {63'd0, bus.mem_en}, 64'd0);
      bus.req0 = 1'b0;
      step();
      chk("to_pulse", {62'd0, bus.ack0, bus.err0}, 64'd0);
      wait_n = 0;
      bus.req0 = 1'b1; bus.addr0 = 32'h104;
      push(1'b0, 1'b0, 1'b0, 32'h104);
      wait_ack("to_next_ack", 10);
      chk("to_next_err", {63'd0, bus.err0}, 64'd0);
      bus.req0 = 1'b0;
      step();

      // ---- late changes after grant, req1 pulse only during BUSY, req0 dropped
      wait_n = 3;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h600;
      push(1'b0, 1'b0, 1'b0, 32'h600);
      step();
      bus.addr0 = 32'h7FC; bus.we0 = 1'b1; bus.wdata0 = 32'hCAFE;
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h900;
      chk("lc_mem_addr_1", {32'd0, bus.mem_addr}, 64'h600);
      step();
      bus.req1 = 1'b0; bus.req0 = 1'b0;
      chk("lc_mem_addr_2", {32'd0, bus.mem_addr}, 64'h600);
      chk("lc_mem_we", {63'd0, bus.mem_we}, 64'd0);
      wait_ack("lc_ack0", 10);
      chk("lc_ack_port0", {63'd0, bus.ack0}, 64'd1);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("lc_no_ack1", {62'd0, bus.ack1, busy}, 64'd0);
      end
      chk("lc_mem_addr_hold", {32'd0, bus.mem_addr}, 64'h600);

      // ---- port 1 write with three wait states
      wait_n = 3;
      bus.we0 = 1'b0;
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h40; bus.wdata1 = 32'h12345678;
      push(1'b1, 1'b0, 1'b1, 32'h40);
      for (int c = 1; c <= 4; c++) begin
         step();
         chk("wr_mem_we", {62'd0, bus.mem_en, bus.mem_we}, 64'd3);
         chk("wr_mem_addr", {32'd0, bus.mem_addr}, 64'h40);
         chk("wr_mem_wdata", {32'd0, bus.mem_wdata}, 64'h12345678);
         chk("wr_ack_early", {63'd0, bus.ack1}, 64'd0);
      end
      step();
      chk("wr_ack1_c5", {63'd0, bus.ack1}, 64'd1);
      chk("wr_rdata_kept", {32'd0, bus.rdata}, {32'd0, mdl(32'h600)});
      bus.req1 = 1'b0;
      step(); step();

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
